// File: rtl/zdraw_scheduler.sv
// zdraw_scheduler: drives the ZDrawCore en/cmd/data/done handshake from a
// slot table. Init slots run once per enable, then periodic slots loop,
// each drawn always, on data change, once, or never. Every command is
// covered by a down-counting watchdog.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | disabled, core enable low
// SETTLE | one quiet cycle after enable, pointer reset to slot 0
// SELECT | evaluate current slot, latch command if it is to be issued
// ISSUE  | core enable high, waiting for done or watchdog expiry
// GAP    | core enable low, waiting for the core to release done
// NEXT   | advance pointer, wrap to first periodic slot at loop end
module zdraw_scheduler #(
    parameter int NUM_SLOTS      = 16,
    parameter int INIT_SLOTS     = 3,
    parameter int CMD_W          = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [NUM_SLOTS*CMD_W-1:0]        i_slot_cmd,
    input  logic [NUM_SLOTS*DATA_W-1:0]       i_slot_data1,
    input  logic [NUM_SLOTS*DATA_W-1:0]       i_slot_data2,
    input  logic [NUM_SLOTS*2-1:0]            i_slot_mode,
    input  logic                              i_force_redraw,
    output logic                              o_core_en,
    output logic [CMD_W-1:0]                  o_core_cmd,
    output logic [DATA_W-1:0]                 o_core_data1,
    output logic [DATA_W-1:0]                 o_core_data2,
    input  logic                              i_core_done,
    output logic [$clog2(NUM_SLOTS)-1:0]      o_cur_slot,
    output logic                              o_busy,
    output logic                              o_frame_done,
    output logic [15:0]                       o_frame_cnt,
    output logic                              o_timeout_err
);

    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [PTR_W-1:0] LAST_SLOT      = PTR_W'(NUM_SLOTS - 1);
    localparam logic [PTR_W-1:0] FIRST_PERIODIC = PTR_W'(INIT_SLOTS);
    localparam logic [WD_W-1:0]  WD_LOAD        = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, SELECT, ISSUE, GAP, NEXT
    } state_t;

    state_t                state;
    logic [WD_W-1:0]       wdog;
    logic                  firstCycle;
    logic [NUM_SLOTS-1:0]  dirty;
    logic [NUM_SLOTS-1:0]  onceDone;
    logic [NUM_SLOTS-1:0]  setDirty;
    logic [2*DATA_W-1:0]   shadow [NUM_SLOTS];

    logic [CMD_W-1:0]      selCmd;
    logic [DATA_W-1:0]     selData1;
    logic [DATA_W-1:0]     selData2;
    logic [1:0]            selMode;
    logic                  selDirty;
    logic                  selOnce;
    logic                  issueNow;
    logic                  doneAccept;

    // A done is only honoured after the first ISSUE cycle, so a stale done
    // left over from the previous command is never taken as completion.
    assign doneAccept = (state == ISSUE) && en && !firstCycle && i_core_done;

    // Mux the currently pointed-at slot out of the flat slot table.
    always_comb begin
        selCmd   = '0;
        selData1 = '0;
        selData2 = '0;
        selMode  = '0;
        selDirty = 1'b0;
        selOnce  = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (o_cur_slot == PTR_W'(k)) begin
                selCmd   = i_slot_cmd[k*CMD_W +: CMD_W];
                selData1 = i_slot_data1[k*DATA_W +: DATA_W];
                selData2 = i_slot_data2[k*DATA_W +: DATA_W];
                selMode  = i_slot_mode[k*2 +: 2];
                selDirty = dirty[k];
                selOnce  = onceDone[k];
            end
        end
    end

    // Issue decision for the current slot; init slots ignore their mode.
    always_comb begin
        issueNow = 1'b0;
        if (o_cur_slot < FIRST_PERIODIC) begin
            issueNow = 1'b1;
        end else begin
            case (selMode)
                2'b01:   issueNow = 1'b1;
                2'b10:   issueNow = selDirty;
                2'b11:   issueNow = !selOnce;
                default: issueNow = 1'b0;
            endcase
        end
    end

    // Change detection. On the cycle a slot completes, compare against the
    // data it is about to be shadowed with, otherwise the stale shadow would
    // re-mark the slot dirty and it would be redrawn with unchanged data.
    always_comb begin
        logic [2*DATA_W-1:0] cmpRef;
        cmpRef   = '0;
        setDirty = {NUM_SLOTS{i_force_redraw}};
        for (int k = 0; k < NUM_SLOTS; k++) begin
            cmpRef = shadow[k];
            if (doneAccept && (o_cur_slot == PTR_W'(k)))
                cmpRef = {o_core_data1, o_core_data2};
            if ((i_slot_mode[k*2 +: 2] == 2'b10) &&
                ({i_slot_data1[k*DATA_W +: DATA_W],
                  i_slot_data2[k*DATA_W +: DATA_W]} != cmpRef))
                setDirty[k] = 1'b1;
        end
    end

    // Per-slot dirty / once-done / shadow bookkeeping; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty    <= '1;
            onceDone <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) shadow[k] <= '0;
        end else if (!en) begin
            dirty    <= '1;
            onceDone <= '0;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (setDirty[k])
                    dirty[k] <= 1'b1;
                else if (doneAccept && (o_cur_slot == PTR_W'(k)))
                    dirty[k] <= 1'b0;
                if (doneAccept && (o_cur_slot == PTR_W'(k))) begin
                    onceDone[k] <= 1'b1;
                    shadow[k]   <= {o_core_data1, o_core_data2};
                end
            end
        end
    end

    // Sequencer FSM with registered core interface and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wdog          <= '0;
            firstCycle    <= 1'b0;
            o_core_en     <= 1'b0;
            o_core_cmd    <= '0;
            o_core_data1  <= '0;
            o_core_data2  <= '0;
            o_cur_slot    <= '0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_cnt   <= '0;
            o_timeout_err <= 1'b0;
        end else if (!en) begin
            state         <= IDLE;
            firstCycle    <= 1'b0;
            o_core_en     <= 1'b0;
            o_busy        <= 1'b0;
            o_cur_slot    <= '0;
            o_frame_done  <= 1'b0;
            o_frame_cnt   <= '0;
            o_timeout_err <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                IDLE: state <= SETTLE;
                SETTLE: begin
                    o_cur_slot <= '0;
                    state      <= SELECT;
                end
                SELECT: begin
                    if (issueNow) begin
                        o_core_cmd   <= selCmd;
                        o_core_data1 <= selData1;
                        o_core_data2 <= selData2;
                        o_core_en    <= 1'b1;
                        o_busy       <= 1'b1;
                        wdog         <= WD_LOAD;
                        firstCycle   <= 1'b1;
                        state        <= ISSUE;
                    end else begin
                        state <= NEXT;
                    end
                end
                ISSUE: begin
                    firstCycle <= 1'b0;
                    if (doneAccept) begin
                        o_core_en <= 1'b0;
                        o_busy    <= 1'b0;
                        state     <= GAP;
                    end else if (wdog == '0) begin
                        o_core_en     <= 1'b0;
                        o_busy        <= 1'b0;
                        o_timeout_err <= 1'b1;
                        state         <= GAP;
                    end else begin
                        wdog <= wdog - 1'b1;
                    end
                end
                GAP: begin
                    if (!i_core_done) state <= NEXT;
                end
                NEXT: begin
                    if (o_cur_slot != LAST_SLOT) begin
                        o_cur_slot <= o_cur_slot + 1'b1;
                    end else begin
                        o_cur_slot   <= FIRST_PERIODIC;
                        o_frame_done <= 1'b1;
                        o_frame_cnt  <= o_frame_cnt + 16'd1;
                    end
                    state <= SELECT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zdraw_scheduler.sv
// tb_zdraw_scheduler: directed bench for zdraw_scheduler with a small
// draw-core model that answers done a few cycles after enable.
module tb_zdraw_scheduler;

    localparam int NS = 16;
    localparam int IS = 3;
    localparam int CW = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [NS*CW-1:0]  slotCmd;
    logic [NS*DW-1:0]  slotData1;
    logic [NS*DW-1:0]  slotData2;
    logic [NS*2-1:0]   slotMode;
    logic              forceRedraw = 1'b0;
    logic              coreEn;
    logic [CW-1:0]     coreCmd;
    logic [DW-1:0]     coreData1;
    logic [DW-1:0]     coreData2;
    logic              coreDone = 1'b0;
    logic [3:0]        curSlot;
    logic              busy;
    logic              frameDone;
    logic [15:0]       frameCnt;
    logic              timeoutErr;

    zdraw_scheduler #(
        .NUM_SLOTS(NS), .INIT_SLOTS(IS), .CMD_W(CW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i_slot_cmd(slotCmd), .i_slot_data1(slotData1), .i_slot_data2(slotData2),
        .i_slot_mode(slotMode), .i_force_redraw(forceRedraw),
        .o_core_en(coreEn), .o_core_cmd(coreCmd), .o_core_data1(coreData1),
        .o_core_data2(coreData2), .i_core_done(coreDone), .o_cur_slot(curSlot),
        .o_busy(busy), .o_frame_done(frameDone), .o_frame_cnt(frameCnt),
        .o_timeout_err(timeoutErr)
    );

    always #5 clk = ~clk;

    // Draw-core model: done 5 cycles into enable, held until enable drops
    // plus holdExtra cycles; slots flagged in noDone never answer.
    int coreCnt = 0;
    int dropCnt = 0;
    int holdExtra = 0;
    bit noDone [NS];
    always @(posedge clk) begin
        if (coreEn) begin
            dropCnt <= 0;
            if (!noDone[int'(curSlot)] && coreCnt == 4) coreDone <= 1'b1;
            coreCnt <= coreCnt + 1;
        end else begin
            coreCnt <= 0;
            if (coreDone) begin
                if (dropCnt >= holdExtra) coreDone <= 1'b0;
                else dropCnt <= dropCnt + 1;
            end
        end
    end

    // Monitor: logs each issue, enable-high lengths and gaps between issues.
    int issLog [$];
    int lenLog [$];
    int gapLog [$];
    logic [DW-1:0] d1Log [$];
    int frames = 0, overlap = 0, busyBad = 0, unstable = 0;
    int highCnt = 0, lowCnt = 0;
    logic prevEn = 1'b0;
    logic [CW-1:0] issCmd = '0;
    always @(negedge clk) begin
        if (busy !== coreEn) busyBad++;
        if (frameDone) frames++;
        if (coreEn) begin
            if (!prevEn) begin
                issLog.push_back(int'(curSlot));
                d1Log.push_back(coreData1);
                gapLog.push_back(lowCnt);
                if (coreDone) overlap++;
                issCmd  = coreCmd;
                highCnt = 1;
            end else begin
                highCnt++;
                if (coreCmd !== issCmd) unstable++;
            end
        end else begin
            if (prevEn) begin
                lenLog.push_back(highCnt);
                lowCnt = 1;
            end else begin
                lowCnt++;
            end
        end
        prevEn = coreEn;
    end

    int tests = 0;
    int fails = 0;
    int expq [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clearLogs();
        issLog.delete();
        lenLog.delete();
        gapLog.delete();
        d1Log.delete();
    endtask

    task automatic expLoop(input int lo, input int hi, input logic [15:0] skip);
        expq.delete();
        for (int i = lo; i <= hi; i++) if (!skip[i]) expq.push_back(i);
    endtask

    function automatic bit logMatches();
        if (issLog.size() != expq.size()) return 1'b0;
        foreach (expq[i]) if (issLog[i] != expq[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkSeq(input string tag);
        check({tag, " count"}, 64'(issLog.size()), 64'(expq.size()));
        check({tag, " order"}, 64'(logMatches()), 64'd1);
    endtask

    task automatic waitFrames(input int n);
        int target;
        int budget;
        target = frames + n;
        budget = 0;
        while (frames < target && budget < 3000) begin
            tick();
            budget++;
        end
        check("frame wait bound", 64'(frames >= target), 64'd1);
    endtask

    initial begin
        int cnt;
        for (int k = 0; k < NS; k++) begin
            slotCmd[k*CW +: CW]   = CW'(k);
            slotData1[k*DW +: DW] = 32'h1000 + DW'(k);
            slotData2[k*DW +: DW] = 32'h2000 + DW'(k);
            slotMode[k*2 +: 2]    = 2'b01;
            noDone[k]             = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        check("rst core_en", 64'(coreEn), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst frame_done", 64'(frameDone), 64'd0);
        check("rst frame_cnt", 64'(frameCnt), 64'd0);
        check("rst timeout_err", 64'(timeoutErr), 64'd0);
        check("rst cur_slot", 64'(curSlot), 64'd0);
        check("rst core_cmd", 64'(coreCmd), 64'd0);
        check("rst core_data1", 64'(coreData1), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle core_en", 64'(coreEn), 64'd0);

        // All periodic slots mode 01
        clearLogs();
        en = 1'b1;
        waitFrames(1);
        check("loop1 frame_cnt", 64'(frameCnt), 64'd1);
        expLoop(0, 15, 16'h0000);
        checkSeq("loop1 all");
        check("done len", 64'(lenLog[0]), 64'd6);
        check("normal gap", 64'(gapLog[1]), 64'd4);
        check("slot3 data1", 64'(d1Log[3]), 64'h1003);
        clearLogs();
        waitFrames(1);
        check("loop2 frame_cnt", 64'(frameCnt), 64'd2);
        clearLogs();
        waitFrames(1);
        check("loop3 frame_cnt", 64'(frameCnt), 64'd3);
        expLoop(3, 15, 16'h0000);
        checkSeq("loop3 periodic");
        check("no timeout", 64'(timeoutErr), 64'd0);

        // On-change slot 5 and once slot 7
        en = 1'b0;
        tick();
        slotMode[5*2 +: 2] = 2'b10;
        slotMode[7*2 +: 2] = 2'b11;
        slotData1[5*DW +: DW] = 32'h1234;
        clearLogs();
        en = 1'b1;
        waitFrames(1);
        expLoop(0, 15, 16'h0000);
        checkSeq("chg loop1");
        clearLogs();
        waitFrames(1);
        expLoop(3, 15, 16'h00A0);
        checkSeq("chg loop2 skip");
        clearLogs();
        slotData1[5*DW +: DW] = 32'h1235;
        waitFrames(1);
        expLoop(3, 15, 16'h0080);
        checkSeq("chg loop3 redraw");
        check("chg data1", 64'(d1Log[2]), 64'h1235);
        clearLogs();
        forceRedraw = 1'b1;
        tick();
        forceRedraw = 1'b0;
        waitFrames(1);
        expLoop(3, 15, 16'h0080);
        checkSeq("force redraw");
        clearLogs();
        waitFrames(1);
        expLoop(3, 15, 16'h00A0);
        checkSeq("after force");

        // Re-enable reruns init slots and once slot
        en = 1'b0;
        tick();
        en = 1'b1;
        clearLogs();
        waitFrames(1);
        expLoop(0, 15, 16'h0000);
        checkSeq("reenable");
        check("reenable frame_cnt", 64'(frameCnt), 64'd1);

        // Watchdog on slot 4
        slotMode[5*2 +: 2] = 2'b01;
        slotMode[7*2 +: 2] = 2'b01;
        noDone[4] = 1'b1;
        clearLogs();
        waitFrames(1);
        expLoop(3, 15, 16'h0000);
        checkSeq("timeout loop");
        check("timeout len", 64'(lenLog[1]), 64'd16);
        check("timeout gap", 64'(gapLog[2]), 64'd3);
        check("timeout_err set", 64'(timeoutErr), 64'd1);
        noDone[4] = 1'b0;
        clearLogs();
        waitFrames(1);
        check("timeout_err sticky", 64'(timeoutErr), 64'd1);
        check("slot4 recovers", 64'(lenLog[1]), 64'd6);

        // Drop enable during ISSUE of slot 9
        cnt = 0;
        while (!(coreEn && curSlot == 4'd9) && cnt < 500) begin
            tick();
            cnt++;
        end
        check("reach slot9", 64'(coreEn && curSlot == 4'd9), 64'd1);
        en = 1'b0;
        tick();
        check("drop core_en", 64'(coreEn), 64'd0);
        check("drop busy", 64'(busy), 64'd0);
        check("drop timeout_err", 64'(timeoutErr), 64'd0);
        check("drop frame_cnt", 64'(frameCnt), 64'd0);
        en = 1'b1;
        clearLogs();
        cnt = 0;
        while (!coreEn && cnt < 20) begin
            tick();
            cnt++;
        end
        check("settle latency", 64'(cnt), 64'd3);
        check("first slot", 64'(curSlot), 64'd0);
        check("first cmd", 64'(coreCmd), 64'd0);
        check("first data1", 64'(coreData1), 64'h1000);
        slotCmd[0 +: CW] = 4'hA;
        tick();
        check("cmd hold", 64'(coreCmd), 64'd0);
        slotCmd[0 +: CW] = 4'h0;

        // Core holds done after enable drop
        holdExtra = 3;
        clearLogs();
        waitFrames(1);
        expLoop(1, 15, 16'h0000);
        checkSeq("held done");
        check("held gap a", 64'(gapLog[0]), 64'd7);
        check("held gap b", 64'(gapLog[4]), 64'd7);

        // All periodic slots skipped
        holdExtra = 0;
        for (int k = IS; k < NS; k++) slotMode[k*2 +: 2] = 2'b00;
        waitFrames(1);
        clearLogs();
        cnt = 0;
        begin
            int target;
            target = frames + 1;
            while (frames < target && cnt < 200) begin
                tick();
                cnt++;
            end
        end
        check("skip period", 64'(cnt), 64'd26);
        check("skip no issue", 64'(issLog.size()), 64'd0);

        check("no overlap", 64'(overlap), 64'd0);
        check("busy tracks en", 64'(busyBad), 64'd0);
        check("cmd stable", 64'(unstable), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zdraw_scheduler.md
Name: zdraw_scheduler

Overview:
Parametrised successor to the fixed-sequence draw adapter. It drives the ZDrawCore en/cmd/data/done handshake from a configurable slot table instead of a hard-coded step list. It runs one-shot init slots once after enable, then loops over periodic slots. Each periodic slot is drawn always, only when its data changes, or never, and every command is covered by a watchdog. It sits between the UI/measurement registers and the draw core; SDRAM traffic stays inside the core.

Parameters:
NUM_SLOTS, 16, total slot count; slot 0 is issued first.
INIT_SLOTS, 3, slots 0..INIT_SLOTS-1 run once per enable; must be 1..NUM_SLOTS-1.
CMD_W, 4, draw-core command width.
DATA_W, 32, width of each of data1/data2.
TIMEOUT_CYCLES, 2**24, cycles to wait for core done before aborting a command; must be >= 2.

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous, active-low.
en  in  1  scheduler enable; low forces IDLE.
i_slot_cmd  in  NUM_SLOTS*CMD_W  per-slot command code, slot k at [k*CMD_W +: CMD_W].
i_slot_data1  in  NUM_SLOTS*DATA_W  per-slot data1.
i_slot_data2  in  NUM_SLOTS*DATA_W  per-slot data2.
i_slot_mode  in  NUM_SLOTS*2  per-slot mode: 00 skip, 01 always, 10 on-change, 11 once-per-enable. Ignored for init slots, which are always issued.
i_force_redraw  in  1  pulse; marks every on-change slot dirty.
o_core_en  out  1  draw-core enable.
o_core_cmd  out  CMD_W  command to core.
o_core_data1  out  DATA_W  data1 to core.
o_core_data2  out  DATA_W  data2 to core.
i_core_done  in  1  draw-core done (level, held until en drops).
o_cur_slot  out  clog2(NUM_SLOTS)  slot currently selected/issued.
o_busy  out  1  high while o_core_en is high.
o_frame_done  out  1  one-cycle pulse at each periodic-loop wrap.
o_frame_cnt  out  16  periodic loops completed since enable; wraps at 0xFFFF to 0.
o_timeout_err  out  1  sticky; set by watchdog abort; cleared only by reset or en low.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Dirty bits all 1; once-done bits 0; shadow data registers 0.
- State machine:
  - IDLE: when en=1, go to SETTLE.
  - SETTLE: exactly 1 cycle with o_core_en=0. Then slot pointer = 0 and go to SELECT.
  - SELECT: 1 cycle; evaluates the current slot.
    - Issue if the slot is an init slot, or mode=01, or (mode=10 and the slot is dirty), or (mode=11 and once-done=0).
    - On issue, latch cmd/data1/data2 into the o_core_* registers and go to ISSUE.
    - Otherwise go to NEXT.
  - ISSUE: o_core_en=1, watchdog counting.
    - On i_core_done=1: o_core_en=0 in the following cycle. Update shadow data with the latched data, clear dirty, set once-done, go to GAP.
    - On watchdog reaching TIMEOUT_CYCLES: o_core_en=0, set o_timeout_err. Dirty/once-done are not updated. Go to GAP.
  - GAP: o_core_en=0. Stay until i_core_done=0, then go to NEXT. The next issue therefore never overlaps a stale done.
  - NEXT:
    - If pointer < NUM_SLOTS-1: pointer+1, go to SELECT.
    - Else: pointer = INIT_SLOTS, pulse o_frame_done, increment o_frame_cnt, go to SELECT.
    - Init slots are never revisited until re-enable.
- Latency: from SELECT (issue) to o_core_en=1 is 1 cycle. o_core_cmd/data are stable for the entire o_core_en high period and do not follow input changes while in ISSUE.
- Change detection:
  - Every cycle, for each mode-10 slot, compare {data1,data2} with its shadow; a mismatch sets dirty.
  - i_force_redraw sets all dirty bits.
  - If a set and a clear of the same slot's dirty bit happen in the same cycle, set wins.
- en low in any state:
  - Next cycle: o_core_en=0, state IDLE, o_busy=0.
  - once-done cleared, all dirty bits set, o_timeout_err and o_frame_cnt cleared.
  - The next en rise re-runs the init slots.
- All-skip configuration (every periodic slot mode 00): the loop still cycles through SELECT/NEXT and pulses o_frame_done every (NUM_SLOTS-INIT_SLOTS)*2 cycles. No o_core_en is generated.
- i_core_done already high on entry to SELECT: treated as stale; the command is still issued. ISSUE ignores done during its first cycle.

Test Plan:
1. NUM_SLOTS=16, INIT_SLOTS=3, all periodic modes 01, core model answers done 5 cycles after en -> cmds 0,1,2 once, then slots 3..15 repeat; o_frame_done every loop; o_frame_cnt increments 1,2,3.
2. Slot 5 mode 10 with data1 fixed at 0x1234 -> drawn once in loop 1, skipped in loop 2. Change data1 to 0x1235 -> drawn in loop 3 with o_core_data1=0x1235. Pulse i_force_redraw -> drawn again in the next loop.
3. Slot 7 mode 11 -> issued only in loop 1. Toggle en low 1 cycle then high -> slots 0..2 and slot 7 are reissued.
4. TIMEOUT_CYCLES=16, core never asserts done on slot 4 -> o_core_en drops after 16 cycles; o_timeout_err=1 and stays set; slot 5 issued next.
5. Drop en while in ISSUE on slot 9 -> o_core_en=0 next cycle, o_busy=0. Re-enable -> the first command is slot 0 after the 1-cycle SETTLE.
6. Core holds done high 3 cycles after en drop -> scheduler stays in GAP; next o_core_en rises only after done=0; no back-to-back overlap.
